heavy_part_table_dump1: RTL and testbench
=========================================

// Module: heavy_part_table_dump1
// PURPOSE
//  Readout engine for heavy-part table 1; the reader for what heavy_part_table_compare1 writes.
//  On a host request it freezes the update path and scans all buckets of the 96x4096 bucket RAM.
//  Each bucket is streamed out as index+value with wr/alf flow control, optionally clearing it.
//  Sits beside heavy_part_table_top1 and shares the RAM through its second port pair (mux at top).
// PARAMETERS
//  ADDR_W      12  bucket index width (4096 buckets)
//  DATA_W      96  bucket word width
//  RAM_RD_LAT  2   cycles from rden/rdaddr to valid q (ram_96_4096 with output register)
//  CLEAR_ON_RD 1   1: write zero back to each bucket after reading it
//  SKIP_ZERO   0   1: suppress output of all-zero buckets (still counted/cleared)
// PORTS
//  clk            in   1    clock
//  reset          in   1    synchronous, active-low reset
//  dump_req       in   1    1-cycle pulse: start a full-table dump
//  dump_busy      out  1    high from accepted dump_req until dump_done
//  dump_done      out  1    1-cycle pulse when last bucket has been emitted/cleared
//  freeze_req     out  1    ask update pipeline to stop accepting keys and drain
//  freeze_ack     in   1    update pipeline drained and idle (level)
//  ram_rden       out  1    RAM read enable
//  ram_rdaddr     out  12   RAM read address
//  ram_rdvalue    in   96   RAM read data, valid RAM_RD_LAT cycles after ram_rden
//  ram_wren       out  1    RAM write enable (clear)
//  ram_wraddr     out  12   RAM write address
//  ram_wrvalue    out  96   RAM write data (always 0)
//  bucket_out_wr  out  1    output entry valid
//  bucket_out     out  128  {20'd0, index[11:0], value[95:0]}
//  bucket_out_alf in   1    downstream FIFO almost full; headroom >= RAM_RD_LAT+1 entries
// BEHAVIOUR
//  Reset (reset==0 at clk edge): state IDLE; all outputs 0; addr counter 0; read pipe flushed.
//  FSM: IDLE -> FREEZE -> SCAN -> DRAIN -> DONE -> IDLE.
//   IDLE:   dump_req=1 -> FREEZE; dump_busy=1 from next cycle.
//   FREEZE: freeze_req=1; freeze_ack=1 -> SCAN (stays in FREEZE indefinitely otherwise).
//   SCAN:   each cycle with bucket_out_alf==0 issue ram_rden=1, ram_rdaddr=cnt, cnt++.
//           alf==1 -> no issue that cycle; in-flight reads still land and are emitted.
//           cnt is ADDR_W+1 bits; after issuing index 4095 (cnt==4096) -> DRAIN.
//   DRAIN:  wait until read pipe empty (RAM_RD_LAT cycles after last issue) -> DONE.
//   DONE:   dump_done=1 one cycle, freeze_req and dump_busy drop same cycle -> IDLE.
//  Read pipe: RAM_RD_LAT-deep shift of {valid, index}. On pipe-out valid:
//   bucket_out_wr=1, bucket_out={20'd0,idx,ram_rdvalue} registered (emit latency RAM_RD_LAT+1),
//   unless SKIP_ZERO && ram_rdvalue==0.
//   CLEAR_ON_RD: ram_wren=1, ram_wraddr=idx, ram_wrvalue=0 in the same cycle ram_rdvalue is valid.
//   Write index always < current read index, so no same-address read/write collision.
//  Every index 0..4095 emitted exactly once, in ascending order (SKIP_ZERO=0).
//  dump_req while dump_busy=1: ignored, no queuing.
//  freeze_ack dropping during SCAN: protocol error, ignored (dump continues).
//  reset mid-dump: abort immediately, no dump_done, freeze_req=0 next cycle; partial clears stand.
//  Outside dump: ram_rden=ram_wren=bucket_out_wr=0 so top-level mux grants RAM to update path.
// STRUCTURE
//  Shared header heavy_part_defs.vh: ADDR_W, DATA_W, BUCKETS=4096, output word layout
//   (OUT_IDX_LSB=96, OUT_W=128), FSM state encodings.
//  One sub-module: heavy_part_rd_pipe (parameterised valid+index delay line of RAM_RD_LAT).
//  FSM, counter and output/clear register stage in this module.
// TESTING
//  1 Preload RAM[i]=i+1, dump_req, freeze_ack=1 after 5 cycles -> 4096 entries idx 0..4095,
//    value i+1, dump_done once, RAM all zero afterwards.
//  2 Same with bucket_out_alf high cycles 100-199 of SCAN -> no rden in those cycles, no loss/dup,
//    <=RAM_RD_LAT+1 entries emitted after alf rises.
//  3 SKIP_ZERO=1, only RAM[7]=96'h5 and RAM[4095]=96'hFF nonzero -> exactly 2 entries, then done.
//  4 freeze_ack held 0 for 50 cycles -> no ram_rden, freeze_req=1, dump_busy=1 throughout.
//  5 reset low at scan index 1000 -> outputs 0 next cycle, no dump_done; new dump_req restarts at 0.
//  6 dump_req pulsed again mid-SCAN -> single dump, single dump_done, 4096 entries.

Source files
------------

// File: rtl/heavy_part_table_dump1_pkg.sv
// Shared definitions for the heavy-part table 1 readout engine: widths,
// output word layout, FSM states and the output word packer.
package heavy_part_table_dump1_pkg;

  localparam int unsigned ADDR_W      = 12;
  localparam int unsigned DATA_W      = 96;
  localparam int unsigned BUCKETS     = 1 << ADDR_W;
  localparam int unsigned OUT_IDX_LSB = DATA_W;
  localparam int unsigned OUT_W       = 128;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FREEZE = 3'd1,
    ST_SCAN   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Output entry: zero pad, bucket index, bucket value.
  function automatic logic [OUT_W-1:0] pack_entry(input logic [ADDR_W-1:0] idx,
                                                  input logic [DATA_W-1:0] value);
    logic [OUT_W-1:0] word;
    word = '0;
    word[OUT_IDX_LSB +: ADDR_W] = idx;
    word[DATA_W-1:0] = value;
    return word;
  endfunction

endpackage

// File: rtl/heavy_part_table_dump1_if.sv
// RAM second-port pair plus the bucket output stream of the dump engine.
// master: dump engine side; slave: RAM mux / downstream FIFO side.
interface heavy_part_table_dump1_if;
  import heavy_part_table_dump1_pkg::*;

  logic              ram_rden;
  logic [ADDR_W-1:0] ram_rdaddr;
  logic [DATA_W-1:0] ram_rdvalue;
  logic              ram_wren;
  logic [ADDR_W-1:0] ram_wraddr;
  logic [DATA_W-1:0] ram_wrvalue;
  logic              bucket_out_wr;
  logic [OUT_W-1:0]  bucket_out;
  logic              bucket_out_alf;

  modport master (
    output ram_rden, ram_rdaddr, ram_wren, ram_wraddr, ram_wrvalue,
           bucket_out_wr, bucket_out,
    input  ram_rdvalue, bucket_out_alf
  );

  modport slave (
    input  ram_rden, ram_rdaddr, ram_wren, ram_wraddr, ram_wrvalue,
           bucket_out_wr, bucket_out,
    output ram_rdvalue, bucket_out_alf
  );

endinterface

// File: rtl/heavy_part_table_dump1_rd_pipe.sv
// Valid+index delay line matching the RAM read latency, so each returning
// read word can be tagged with the bucket index it came from.
module heavy_part_table_dump1_rd_pipe #(
  parameter int unsigned LAT   = 2,
  parameter int unsigned IDX_W = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_valid,
  input  logic [IDX_W-1:0] issue_idx,
  output logic             land_valid,
  output logic [IDX_W-1:0] land_idx,
  output logic             busy
);

  logic [LAT-1:0]   vld;
  logic [IDX_W-1:0] idx [LAT];

  // Shift issued reads along; reset flushes every stage.
  always_ff @(posedge clk) begin
    if (!reset) begin
      vld <= '0;
      for (int unsigned i = 0; i < LAT; i++) idx[i] <= '0;
    end else begin
      vld[0] <= issue_valid;
      idx[0] <= issue_idx;
      for (int unsigned i = 1; i < LAT; i++) begin
        vld[i] <= vld[i-1];
        idx[i] <= idx[i-1];
      end
    end
  end

  assign land_valid = vld[LAT-1];
  assign land_idx   = idx[LAT-1];
  assign busy       = |vld;

endmodule

// File: rtl/heavy_part_table_dump1.sv
// Readout engine for heavy-part table 1: freezes the update path, scans every
// bucket in ascending order, streams {index, value} out under almost-full
// flow control and optionally clears each bucket behind the read.
module heavy_part_table_dump1
  import heavy_part_table_dump1_pkg::*;
#(
  parameter int unsigned RAM_RD_LAT  = 2,
  parameter bit          CLEAR_ON_RD = 1'b1,
  parameter bit          SKIP_ZERO   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic dump_req,
  output logic dump_busy,
  output logic dump_done,
  output logic freeze_req,
  input  logic freeze_ack,
  heavy_part_table_dump1_if.master bus
);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W:0]   cnt;
  logic              issue;
  logic              issue_last;
  logic              land_valid;
  logic [ADDR_W-1:0] land_idx;
  logic              pipe_busy;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next state and Moore-style status outputs; read issue gated by almost-full.
  always_comb begin
    state_next = state;
    dump_busy  = 1'b0;
    dump_done  = 1'b0;
    freeze_req = 1'b0;
    issue      = 1'b0;
    issue_last = 1'b0;
    case (state)
      ST_IDLE: begin
        if (dump_req) state_next = ST_FREEZE;
      end
      ST_FREEZE: begin
        dump_busy  = 1'b1;
        freeze_req = 1'b1;
        if (freeze_ack) state_next = ST_SCAN;
      end
      ST_SCAN: begin
        dump_busy  = 1'b1;
        freeze_req = 1'b1;
        issue      = !bus.bucket_out_alf && !cnt[ADDR_W];
        issue_last = issue && (cnt[ADDR_W-1:0] == '1);
        if (issue_last) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        dump_busy  = 1'b1;
        freeze_req = 1'b1;
        if (!pipe_busy) state_next = ST_DONE;
      end
      ST_DONE: begin
        dump_done  = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Bucket index counter, one extra bit to mark the end of the table.
  always_ff @(posedge clk) begin
    if (!reset)                cnt <= '0;
    else if (state == ST_IDLE) cnt <= '0;
    else if (issue)            cnt <= cnt + 1'b1;
  end

  heavy_part_table_dump1_rd_pipe #(
    .LAT   (RAM_RD_LAT),
    .IDX_W (ADDR_W)
  ) u_rd_pipe (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (issue),
    .issue_idx   (cnt[ADDR_W-1:0]),
    .land_valid  (land_valid),
    .land_idx    (land_idx),
    .busy        (pipe_busy)
  );

  // RAM port drive: reads at the counter, clears at the landing index, which
  // always trails the read index so the two never collide.
  always_comb begin
    bus.ram_rden    = issue;
    bus.ram_rdaddr  = issue ? cnt[ADDR_W-1:0] : '0;
    bus.ram_wren    = CLEAR_ON_RD && land_valid;
    bus.ram_wraddr  = (CLEAR_ON_RD && land_valid) ? land_idx : '0;
    bus.ram_wrvalue = '0;
  end

  // Output register stage: one entry per landed read, optionally dropping zeros.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.bucket_out_wr <= 1'b0;
      bus.bucket_out    <= '0;
    end else begin
      bus.bucket_out_wr <= land_valid && !(SKIP_ZERO && (bus.ram_rdvalue == '0));
      if (land_valid) bus.bucket_out <= pack_entry(land_idx, bus.ram_rdvalue);
    end
  end

endmodule

// File: tb/tb_heavy_part_table_dump1.sv
// Bench for heavy_part_table_dump1: two instances (plain and zero-skipping)
// each backed by a behavioural 2-cycle-latency RAM; expected output streams
// are built from a snapshot of the RAM contents taken before each dump.
module tb_heavy_part_table_dump1;
  import heavy_part_table_dump1_pkg::*;

  localparam int unsigned LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic req_a, ack_a, busy_a, done_a, frz_a;
  logic req_b, ack_b, busy_b, done_b, frz_b;
  logic [1:0] fill_a;
  logic       fill_b;

  int n_assert = 0;
  int n_fail   = 0;

  heavy_part_table_dump1_if if_a ();
  heavy_part_table_dump1_if if_b ();

  heavy_part_table_dump1 #(.RAM_RD_LAT(LAT), .CLEAR_ON_RD(1'b1), .SKIP_ZERO(1'b0)) u_dut_a (
    .clk(clk), .reset(reset), .dump_req(req_a), .dump_busy(busy_a), .dump_done(done_a),
    .freeze_req(frz_a), .freeze_ack(ack_a), .bus(if_a)
  );

  heavy_part_table_dump1 #(.RAM_RD_LAT(LAT), .CLEAR_ON_RD(1'b1), .SKIP_ZERO(1'b1)) u_dut_b (
    .clk(clk), .reset(reset), .dump_req(req_b), .dump_busy(busy_b), .dump_done(done_b),
    .freeze_req(frz_b), .freeze_ack(ack_b), .bus(if_b)
  );

  // Behavioural RAMs with registered output; fill commands preload in one cycle.
  logic [DATA_W-1:0] mem_a [BUCKETS];
  logic [DATA_W-1:0] mem_b [BUCKETS];
  logic [DATA_W-1:0] a_s1, b_s1;

  always @(posedge clk) begin
    if (if_a.ram_rden) a_s1 <= mem_a[if_a.ram_rdaddr];
    if_a.ram_rdvalue <= a_s1;
    if (if_a.ram_wren) mem_a[if_a.ram_wraddr] <= if_a.ram_wrvalue;
    case (fill_a)
      2'd1: for (int unsigned i = 0; i < BUCKETS; i++) mem_a[i] <= DATA_W'(i + 1);
      2'd2: for (int unsigned i = 0; i < BUCKETS; i++)
              mem_a[i] <= ($urandom_range(0, 2) == 0) ? '0 : {$urandom(), $urandom(), $urandom()};
      2'd3: for (int unsigned i = 0; i < BUCKETS; i++)
              mem_a[i] <= {$urandom(), $urandom(), $urandom()};
      default: ;
    endcase
  end

  always @(posedge clk) begin
    if (if_b.ram_rden) b_s1 <= mem_b[if_b.ram_rdaddr];
    if_b.ram_rdvalue <= b_s1;
    if (if_b.ram_wren) mem_b[if_b.ram_wraddr] <= if_b.ram_wrvalue;
    if (fill_b) begin
      for (int unsigned i = 0; i < BUCKETS; i++) mem_b[i] <= '0;
      mem_b[7]    <= 96'h5;
      mem_b[4095] <= 96'hFF;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_a(input logic [1:0] code);
    fill_a = code;
    tick();
    fill_a = 2'd0;
  endtask

  task automatic run_dump_a(input string name, input int ack_delay, input int alf_lo,
                            input int alf_hi, input bit alf_rand, input int req_again);
    logic [127:0] exp_q[$];
    logic [127:0] obs_q[$];
    int cyc = 0, scan_k = 0, done_cnt = 0, after_done = 0;
    int rden_alf = 0, wait_bad = 0, first_addr = -1, run_emits = 0, max_run = 0;
    int bad = 0, nonzero = 0;
    bit started = 0, cur_alf = 0, prev_alf = 0;
    for (int i = 0; i < int'(BUCKETS); i++) exp_q.push_back({20'd0, 12'(i), mem_a[i]});
    tick();
    req_a = 1'b1; ack_a = 1'b0; if_a.bucket_out_alf = 1'b0;
    #1;
    chk({name, " busy_at_req"}, busy_a, 1'b0);
    while (after_done < 8 && cyc < 20000) begin
      tick();
      cyc++;
      req_a = (cyc == req_again);
      ack_a = (cyc >= ack_delay);
      cur_alf = 1'b0;
      if (started) begin
        scan_k++;
        if (scan_k >= alf_lo && scan_k < alf_hi) cur_alf = 1'b1;
        if (alf_rand && $urandom_range(0, 4) == 0) cur_alf = 1'b1;
      end
      if_a.bucket_out_alf = cur_alf;
      #1;
      if (cyc <= ack_delay && (if_a.ram_rden || !frz_a || !busy_a)) wait_bad++;
      if (if_a.ram_rden) begin
        if (!started) first_addr = int'(if_a.ram_rdaddr);
        started = 1'b1;
        if (cur_alf) rden_alf++;
      end
      if (cur_alf && !prev_alf) run_emits = 0;
      if (cur_alf && if_a.bucket_out_wr) begin
        run_emits++;
        if (run_emits > max_run) max_run = run_emits;
      end
      prev_alf = cur_alf;
      if (if_a.bucket_out_wr) obs_q.push_back(if_a.bucket_out);
      if (done_a) done_cnt++;
      if (done_cnt > 0) after_done++;
    end
    ack_a = 1'b0;
    if_a.bucket_out_alf = 1'b0;
    chk({name, " done_count"}, done_cnt, 1);
    chk({name, " entry_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      if (obs_q[i] !== exp_q[i]) begin
        if (bad == 0) chk({name, " first_bad_entry"}, obs_q[i], exp_q[i]);
        bad++;
      end
    end
    chk({name, " bad_entries"}, bad, 0);
    chk({name, " first_rdaddr"}, first_addr, 0);
    chk({name, " wait_phase_violations"}, wait_bad, 0);
    chk({name, " rden_while_alf"}, rden_alf, 0);
    chk({name, " emits_per_alf_run_ok"}, max_run <= int'(LAT + 1), 1'b1);
    for (int i = 0; i < int'(BUCKETS); i++) if (mem_a[i] !== '0) nonzero++;
    chk({name, " ram_not_cleared"}, nonzero, 0);
    chk({name, " busy_after"}, busy_a, 1'b0);
    chk({name, " freeze_after"}, frz_a, 1'b0);
  endtask

  task automatic run_dump_b();
    logic [127:0] exp_q[$];
    logic [127:0] obs_q[$];
    int cyc = 0, done_cnt = 0, after_done = 0, bad = 0, nonzero = 0;
    for (int i = 0; i < int'(BUCKETS); i++)
      if (mem_b[i] !== '0) exp_q.push_back({20'd0, 12'(i), mem_b[i]});
    tick();
    req_b = 1'b1; ack_b = 1'b1; if_b.bucket_out_alf = 1'b0;
    #1;
    tick();
    req_b = 1'b0;
    #1;
    while (after_done < 6 && cyc < 10000) begin
      tick();
      cyc++;
      #1;
      if (if_b.bucket_out_wr) obs_q.push_back(if_b.bucket_out);
      if (done_b) done_cnt++;
      if (done_cnt > 0) after_done++;
    end
    ack_b = 1'b0;
    chk("skip done_count", done_cnt, 1);
    chk("skip entry_count", obs_q.size(), 2);
    chk("skip model_count", obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      if (obs_q[i] !== exp_q[i]) bad++;
    chk("skip bad_entries", bad, 0);
    if (obs_q.size() == 2) chk("skip entry1", obs_q[1], {20'd0, 12'd4095, 96'hFF});
    for (int i = 0; i < int'(BUCKETS); i++) if (mem_b[i] !== '0) nonzero++;
    chk("skip ram_not_cleared", nonzero, 0);
    chk("skip busy_after", busy_b, 1'b0);
  endtask

  initial begin : main
    logic [DATA_W-1:0] keep_2000, keep_4095;
    int cyc, done_seen;
    bit hit;
    reset = 1'b0;
    req_a = 1'b0; ack_a = 1'b0; req_b = 1'b0; ack_b = 1'b0;
    if_a.bucket_out_alf = 1'b0; if_b.bucket_out_alf = 1'b0;
    fill_a = 2'd0; fill_b = 1'b0;
    repeat (3) tick();
    #1;
    chk("reset busy", {busy_a, busy_b}, 2'b00);
    chk("reset done", {done_a, done_b}, 2'b00);
    chk("reset freeze", {frz_a, frz_b}, 2'b00);
    chk("reset rden", {if_a.ram_rden, if_b.ram_rden}, 2'b00);
    chk("reset wren", {if_a.ram_wren, if_b.ram_wren}, 2'b00);
    chk("reset out_wr", {if_a.bucket_out_wr, if_b.bucket_out_wr}, 2'b00);
    chk("reset out_word", if_a.bucket_out, '0);
    reset = 1'b1;
    tick();

    load_a(2'd1);
    chk("preload sample", mem_a[100], 96'd101);
    run_dump_a("basic", 5, 0, 0, 1'b0, 0);

    load_a(2'd3);
    run_dump_a("alf_window", 1, 100, 200, 1'b0, 0);

    load_a(2'd2);
    run_dump_a("late_ack", 50, 0, 0, 1'b1, 0);

    // Reset in the middle of the scan.
    load_a(2'd3);
    keep_2000 = mem_a[2000];
    keep_4095 = mem_a[4095];
    tick();
    req_a = 1'b1; ack_a = 1'b1;
    #1;
    tick();
    req_a = 1'b0;
    cyc = 0; hit = 1'b0;
    while (!hit && cyc < 3000) begin
      tick();
      cyc++;
      #1;
      if (if_a.ram_rden && if_a.ram_rdaddr == 12'd1000) hit = 1'b1;
    end
    chk("midreset reached_1000", hit, 1'b1);
    reset = 1'b0;
    tick();
    #1;
    chk("midreset freeze", frz_a, 1'b0);
    chk("midreset busy", busy_a, 1'b0);
    chk("midreset done", done_a, 1'b0);
    chk("midreset rden_wren_wr", {if_a.ram_rden, if_a.ram_wren, if_a.bucket_out_wr}, 3'b000);
    chk("midreset out_word", if_a.bucket_out, '0);
    reset = 1'b1;
    ack_a = 1'b0;
    done_seen = 0;
    repeat (20) begin
      tick();
      #1;
      if (done_a || busy_a) done_seen++;
    end
    chk("midreset no_done", done_seen, 0);
    chk("midreset cleared_0", mem_a[0], '0);
    chk("midreset kept_2000", mem_a[2000], keep_2000);
    chk("midreset kept_4095", mem_a[4095], keep_4095);
    run_dump_a("restart", 3, 0, 0, 1'b0, 0);

    load_a(2'd3);
    run_dump_a("req_again", 2, 0, 0, 1'b0, 500);

    fill_b = 1'b1;
    tick();
    fill_b = 1'b0;
    run_dump_b();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
